// File: rtl/fabulous_alu_pkg.sv
// Shared definitions for the sequential slice-wise add/sub unit.
package fabulous_alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/fabulous_alu_slice.sv
// One carry-chain slice: y = a + b + ci, plus carry into and out of the slice MSB.
module fabulous_alu_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] y,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] sum;

  assign sum      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign y        = sum[W-1:0];
  assign co       = sum[W];
  // MSB sum bit = a ^ b ^ cin, so cin is recoverable from the result
  assign c_msb_in = a[W-1] ^ b[W-1] ^ y[W-1];

endmodule

// File: rtl/fabulous_alu_seq.sv
// Multi-requester add/sub unit: round-robin grant, then one SLICE_W slice per cycle.
// state | meaning
// IDLE  | waiting for a request, round-robin grant
// RUN   | processing slice cnt, LSB slice first
// DONE  | result held until rsp_ready
module fabulous_alu_seq
  import fabulous_alu_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int SLICE_W = 8,
  parameter  int NREQ    = 2,
  localparam int ID_W    = id_width(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_y,
  output logic                   rsp_co,
  output logic                   rsp_ovf,
  output logic [ID_W-1:0]        rsp_id
);

  localparam int N     = DATA_W / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if ((DATA_W % SLICE_W) != 0 || DATA_W < SLICE_W) begin : g_bad_width
      $error("fabulous_alu_seq: DATA_W must be a positive multiple of SLICE_W");
    end
  endgenerate

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               carry_q;
  logic [ID_W-1:0]    rr_ptr;
  logic [DATA_W-1:0]  a_q, bb_q, res_q;
  logic [ID_W-1:0]    id_q;
  logic               co_q, ovf_q;

  logic               grant_any, grant;
  logic [ID_W-1:0]    grant_idx;
  int                 cand;
  logic               last_slice;
  logic [SLICE_W-1:0] s_a, s_b, s_y;
  logic               s_co, s_cmsb;
  logic [DATA_W-1:0]  g_a, g_b;

  // round-robin search starting at rr_ptr
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand = int'(rr_ptr) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(cand);
      end
    end
  end

  assign grant      = (state == ST_IDLE) && grant_any;
  assign last_slice = (cnt == CNT_W'(N - 1));
  assign g_a        = req_a[int'(grant_idx)*DATA_W +: DATA_W];
  assign g_b        = req_b[int'(grant_idx)*DATA_W +: DATA_W];
  assign s_a        = a_q[int'(cnt)*SLICE_W +: SLICE_W];
  assign s_b        = bb_q[int'(cnt)*SLICE_W +: SLICE_W];

  fabulous_alu_slice #(.W(SLICE_W)) u_slice (
    .a        (s_a),
    .b        (s_b),
    .ci       (carry_q),
    .y        (s_y),
    .co       (s_co),
    .c_msb_in (s_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_any)  state_nxt = ST_RUN;
      ST_RUN:  if (last_slice) state_nxt = ST_DONE;
      ST_DONE: if (rsp_ready)  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && grant) req_ready[grant_idx] = 1'b1;
    rsp_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      carry_q <= 1'b0;
      rr_ptr  <= '0;
      a_q     <= '0;
      bb_q    <= '0;
      res_q   <= '0;
      id_q    <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (grant) begin
      a_q     <= g_a;
      bb_q    <= req_sub[grant_idx] ? ~g_b : g_b;
      carry_q <= req_sub[grant_idx];
      id_q    <= grant_idx;
      cnt     <= '0;
      rr_ptr  <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if (state == ST_RUN) begin
      res_q[int'(cnt)*SLICE_W +: SLICE_W] <= s_y;
      carry_q <= s_co;
      if (last_slice) begin
        cnt   <= '0;
        co_q  <= s_co;
        ovf_q <= s_cmsb ^ s_co;
      end else begin
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  assign rsp_y   = res_q;
  assign rsp_co  = co_q;
  assign rsp_ovf = ovf_q;
  assign rsp_id  = id_q;

endmodule

// File: doc/fabulous_alu_seq.md
FABULOUS_ALU_SEQ -- requirements
Module: fabulous_alu_seq

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width in bits.
REQ-002 Parameter SLICE_W, default 8, width of the carry-chain slice processed per cycle; DATA_W SHALL be an integer multiple of SLICE_W (elaboration error otherwise).
REQ-003 Parameter NREQ, default 2, number of requesters; ID_W = max(1, clog2(NREQ)).
REQ-004 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 RSTN  in  1  reset; asynchronous and active-low.
REQ-006 req_valid  in  NREQ  per-requester operation request.
REQ-007 req_ready  out  NREQ  per-requester accept strobe, at most one bit high per cycle.
REQ-008 req_a, req_b  in  NREQ*DATA_W each  packed operands; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-009 req_sub  in  NREQ  per-requester op select: 0 = A+B, 1 = A-B.
REQ-010 rsp_valid  out  1  result available.
REQ-011 rsp_ready  in  1  result consumer accept.
REQ-012 rsp_y  out  DATA_W  sum/difference.
REQ-013 rsp_co  out  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 rsp_ovf  out  1  two's-complement signed overflow.
REQ-015 rsp_id  out  ID_W  index of requester the result belongs to.

Function
REQ-016 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE: if any req_valid, grant one requester by round-robin starting at the index after the last grant (index 0 after reset); assert its req_ready in the same cycle, latch a, b, sub, id; go to RUN.
REQ-018 req_ready SHALL be combinational from req_valid and rr pointer, and SHALL be 0 in RUN and DONE.
REQ-019 Operand conditioning: BB = sub ? ~b : b; initial carry CI = sub.
REQ-020 RUN: one SLICE_W slice per cycle, LSB slice first; slice i computes a[i] + BB[i] + carry_reg; sum bits written into result register, slice carry-out stored in carry_reg for the next cycle.
REQ-021 RUN lasts exactly N = DATA_W/SLICE_W cycles (slice counter 0..N-1); after the last slice go to DONE; N = 1 is legal (one RUN cycle).
REQ-022 rsp_co = carry out of final slice; rsp_ovf = carry into MSB XOR carry out of MSB.
REQ-023 DONE: rsp_valid = 1, outputs stable; on rsp_ready go to IDLE, where a new grant MAY occur in the following cycle (no same-cycle DONE->grant).
REQ-024 Latency: grant cycle T -> rsp_valid first high at T+N+1; throughput one op per N+2 cycles with rsp_ready tied high.
REQ-025 Requesters not granted SHALL keep req_valid held; a requester dropping req_valid before grant is not served; no starvation: a held request is granted within NREQ grants.
REQ-026 rr pointer SHALL advance only on a grant; simultaneous requests always resolve by pointer order, never by fixed priority.
REQ-027 Wrap-around: a+b overflowing DATA_W yields truncated rsp_y with rsp_co = 1.

Reset
REQ-028 RSTN low at any time, including mid-RUN or DONE, SHALL immediately abort: state IDLE, slice counter 0, carry_reg 0, rr pointer 0, result register 0.
REQ-029 Reset values of outputs: req_ready 0 (combinational, no grant while RSTN low), rsp_valid 0, rsp_y 0, rsp_co 0, rsp_ovf 0, rsp_id 0.
REQ-030 An aborted operation SHALL produce no response after reset release.

Structure
REQ-031 FSM state enum and state encoding constants SHALL reside in shared package fabulous_alu_pkg.
REQ-032 Per-slice adder SHALL be a sub-module fabulous_alu_slice (SLICE_W-bit combinational a+b+ci -> y, co, c_msb_in), mappable onto the LUT4_HA carry chain.
REQ-033 No latches; all registers use async active-low reset.

Verification
REQ-034 DATA_W=32, SLICE_W=8: req0 a=0x0000_00FF, b=0x0000_0001, sub=0 -> rsp_y=0x0000_0100, co=0, ovf=0, id=0, rsp_valid at grant+5.
REQ-035 a=0xFFFF_FFFF, b=1, add -> rsp_y=0, co=1, ovf=0; a=0x7FFF_FFFF, b=1 -> rsp_y=0x8000_0000, ovf=1, co=0.
REQ-036 sub: a=5, b=7 -> rsp_y=0xFFFF_FFFE, co=0; a=7, b=5 -> rsp_y=2, co=1.
REQ-037 Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; each response id matches its grant.
REQ-038 RSTN pulsed low during RUN slice 2 -> all outputs 0 immediately, no rsp_valid afterward; next request after release completes correctly.
REQ-039 rsp_ready held low 10 cycles in DONE -> rsp_valid and rsp_y stable, req_ready stays 0, no new grant until one cycle after rsp_ready.
